// File: rtl/gray_tracker_pkg.sv
// Shared types and constants for the Gray-code position tracker.
package gray_tracker_pkg;

    // Tracker FSM states.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Binary deltas that mark one legal step forward or backward.
    localparam logic [2:0] STEP_FWD = 3'd1;
    localparam logic [2:0] STEP_BWD = 3'd7;

    // Forward reflected Gray sequence. Entry i is the Gray code for binary i.
    localparam logic [2:0] GRAY_SEQ [8] = '{
        3'b000, 3'b001, 3'b011, 3'b010,
        3'b110, 3'b111, 3'b101, 3'b100
    };

endpackage

// File: rtl/gray_tracker_if.sv
// Bus between the Gray source (master) and the tracker (slave).
interface gray_tracker_if #(
    parameter int POS_W = 8
);
    logic [2:0]       G;
    logic             sample;
    logic [2:0]       B;
    logic [POS_W-1:0] pos;
    logic             up;
    logic             down;
    logic             err;

    modport master (
        output G, sample,
        input  B, pos, up, down, err
    );

    modport slave (
        input  G, sample,
        output B, pos, up, down, err
    );
endinterface

// File: rtl/gray_tracker_gray_to_bin.sv
// Combinational 3-bit reflected Gray to binary decoder.
module gray_to_bin (
    input  logic [2:0] g,
    output logic [2:0] b
);
    assign b[2] = g[2];
    assign b[1] = g[2] ^ g[1];
    assign b[0] = b[1] ^ g[0];
endmodule

// File: rtl/gray_tracker.sv
// Tracks a 3-bit Gray counter: decodes each accepted sample, counts net
// forward/backward steps and latches a sticky error on any illegal jump.
module gray_tracker
    import gray_tracker_pkg::*;
#(
    parameter int POS_W = 8
) (
    input  logic         clock,
    input  logic         reset,
    gray_tracker_if.slave bus
);

    state_t           state_q, state_d;
    logic [2:0]       b_q, b_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             err_q, err_d;

    logic [2:0]       g_bin;
    logic [2:0]       delta;

    gray_to_bin u_g2b (
        .g (bus.G),
        .b (g_bin)
    );

    // Step size relative to the last accepted position, modulo 8.
    assign delta = g_bin - b_q;

    // Next-state and next-output decision for one accepted sample.
    always_comb begin
        // NOTE: every target gets a default first, so no path through the
        // case can leave a value unassigned and infer a latch.
        state_d = state_q;
        b_d     = b_q;
        pos_d   = pos_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            INIT: begin
                if (bus.sample) begin
                    b_d     = g_bin;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (bus.sample) begin
                    if (delta == STEP_FWD) begin
                        b_d   = g_bin;
                        pos_d = pos_q + 1'b1;
                        up_d  = 1'b1;
                    end else if (delta == STEP_BWD) begin
                        b_d    = g_bin;
                        pos_d  = pos_q - 1'b1;
                        down_d = 1'b1;
                    end else if (delta != 3'd0) begin
                        // Skipped codes: freeze B and pos for diagnosis.
                        err_d   = 1'b1;
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= INIT;
            b_q     <= 3'b000;
            pos_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            pos_q   <= pos_d;
            up_q    <= up_d;
            down_q  <= down_d;
            err_q   <= err_d;
        end
    end

    assign bus.B    = b_q;
    assign bus.pos  = pos_q;
    assign bus.up   = up_q;
    assign bus.down = down_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Self-checking bench for gray_tracker: directed scenarios followed by
// biased random stimulus, compared against a sequence-index model.
module tb_gray_tracker;
    import gray_tracker_pkg::*;

    localparam int POS_W = 8;
    localparam int POS_MOD = 1 << POS_W;

    logic clock;
    logic reset;

    gray_tracker_if #(.POS_W(POS_W)) bus ();

    gray_tracker #(.POS_W(POS_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: position in the forward Gray sequence.
    bit m_valid;
    bit m_err;
    int m_idx;
    int m_pos;
    bit m_up;
    bit m_down;

    function automatic int idx_of(input logic [2:0] g);
        int r = 0;
        for (int i = 0; i < 8; i++)
            if (GRAY_SEQ[i] == g) r = i;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [POS_W-1:0] pe;
        pe = POS_W'(m_pos);
        chk({tag, ".B"},    32'(bus.B),    32'(m_idx));
        chk({tag, ".pos"},  32'(bus.pos),  32'(pe));
        chk({tag, ".up"},   32'(bus.up),   32'(m_up));
        chk({tag, ".down"}, 32'(bus.down), 32'(m_down));
        chk({tag, ".err"},  32'(bus.err),  32'(m_err));
        chk({tag, ".excl"}, 32'(bus.up & bus.down), 32'd0);
    endtask

    // One clock: drive inputs, advance the model, check outputs 1 after the edge.
    task automatic step(input logic [2:0] g, input logic s, input logic r, input string tag);
        int k, d;
        bus.G      = g;
        bus.sample = s;
        reset      = r;
        @(posedge clock);
        #1;
        m_up   = 1'b0;
        m_down = 1'b0;
        if (r) begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_idx   = 0;
            m_pos   = 0;
        end else if (s && !m_err) begin
            k = idx_of(g);
            if (!m_valid) begin
                m_idx   = k;
                m_valid = 1'b1;
            end else begin
                d = (k - m_idx + 8) % 8;
                if (d == 1) begin
                    m_idx = k;
                    m_pos = (m_pos + 1) % POS_MOD;
                    m_up  = 1'b1;
                end else if (d == 7) begin
                    m_idx  = k;
                    m_pos  = (m_pos + POS_MOD - 1) % POS_MOD;
                    m_down = 1'b1;
                end else if (d != 0) begin
                    m_err = 1'b1;
                end
            end
        end
        check_all(tag);
    endtask

    initial begin
        int kind;
        logic [2:0] g;
        bus.G      = 3'b000;
        bus.sample = 1'b0;
        reset      = 1'b1;
        m_valid = 0; m_err = 0; m_idx = 0; m_pos = 0; m_up = 0; m_down = 0;

        // Reset state.
        step(3'b000, 1'b1, 1'b1, "reset");
        step(3'b000, 1'b0, 1'b1, "reset2");

        // Short forward run.
        step(3'b000, 1'b1, 1'b0, "fw_init");
        step(3'b001, 1'b1, 1'b0, "fw1");
        step(3'b011, 1'b1, 1'b0, "fw2");
        step(3'b010, 1'b1, 1'b0, "fw3");

        // Full forward lap ending at 000.
        step(3'b000, 1'b0, 1'b1, "lap_rst");
        step(3'b000, 1'b1, 1'b0, "lap_init");
        for (int i = 1; i <= 8; i++)
            step(GRAY_SEQ[i % 8], 1'b1, 1'b0, "lap");

        // Backward step from 0 wraps pos to all ones.
        step(3'b000, 1'b0, 1'b1, "bw_rst");
        step(3'b000, 1'b1, 1'b0, "bw_init");
        step(3'b100, 1'b1, 1'b0, "bw_wrap");
        step(3'b100, 1'b1, 1'b0, "bw_hold");

        // Idle toggling with sample low.
        for (int i = 0; i < 6; i++)
            step(3'($urandom_range(0, 7)), 1'b0, 1'b0, "idle");

        // Illegal jump, then fault is sticky and ignores further samples.
        step(3'b000, 1'b0, 1'b1, "flt_rst");
        step(3'b000, 1'b1, 1'b0, "flt_init");
        step(3'b011, 1'b1, 1'b0, "flt_jump");
        step(3'b001, 1'b1, 1'b0, "flt_ign1");
        step(3'b000, 1'b1, 1'b0, "flt_ign2");

        // Reset overrides a sample while in FAULT; re-entry goes through INIT.
        step(3'b001, 1'b1, 1'b1, "flt_clear");
        step(3'b010, 1'b1, 1'b0, "reinit");
        step(3'b110, 1'b1, 1'b0, "reinit_fw");

        // Biased random traffic, mostly legal steps with occasional resets.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 19);
            if (kind < 8)       g = GRAY_SEQ[(m_idx + 1) % 8];
            else if (kind < 15) g = GRAY_SEQ[(m_idx + 7) % 8];
            else if (kind < 17) g = GRAY_SEQ[m_idx];
            else                g = 3'($urandom_range(0, 7));
            step(g, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
